dest_track_pipe: RTL and testbench

//  Producer side of the ID-stage forwarding interface: carries destination register,

---
 rtl/dest_track_pipe_pkg.sv | 18 +
 rtl/dest_track_pipe_hazard_detect.sv | 33 +++
 rtl/dest_track_pipe.sv | 90 +++++++++
 tb/tb_dest_track_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dest_track_pipe_pkg.sv
// Shared widths, the register-0 constant and the ID/EX bubble control value
// for the destination-tracking pipeline.
package dest_track_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/dest_track_pipe_hazard_detect.sv
// Combinational stall equations for hazards that ID-stage forwarding cannot
// cover: load-use, and branch operands still being produced in EX or by a load in MEM.
module hazard_detect
  import dest_track_pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              branch,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_wr,
  input  logic              ex_mem_mem_read,
  input  logic [REG_AW-1:0] ex_mem_wr,
  output logic              stall
);

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  function automatic logic uses(input logic [REG_AW-1:0] d,
                                input logic [REG_AW-1:0] a,
                                input logic [REG_AW-1:0] b);
    return (d != '0) && ((d == a) || (d == b));
  endfunction

  logic load_use, br_ex, br_mem;

  assign load_use = id_ex_mem_read && uses(id_ex_wr, rs, rt);
  assign br_ex    = branch && id_ex_reg_write && uses(id_ex_wr, rs, rt);
  assign br_mem   = branch && ex_mem_mem_read && uses(ex_mem_wr, rs, rt);
  assign stall    = load_use | br_ex | br_mem;

endmodule

// File: rtl/dest_track_pipe.sv
// ID/EX, EX/MEM and MEM/WB destination/control/data tracking for ID-stage
// forwarding, with hazard stall generation and a saturating stall counter.
module dest_track_pipe
  import dest_track_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic              ID_Branch,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic [REG_AW-1:0] ID_Write_register,
  input  logic [DATA_W-1:0] EX_ALU_out,
  input  logic [DATA_W-1:0] MEM_Read_data,
  input  logic              flush_ID_EX,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic [REG_AW-1:0] ID_EX_Write_register,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemRead,
  output logic [REG_AW-1:0] EX_MEM_Write_register,
  output logic [DATA_W-1:0] EX_MEM_data,
  output logic              MEM_WB_RegWrite,
  output logic [REG_AW-1:0] MEM_WB_Write_register,
  output logic [DATA_W-1:0] MEM_WB_data,
  output logic              stall_ID,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_t id_ex_ctrl, ex_mem_ctrl;

  assign ID_EX_RegWrite  = id_ex_ctrl.reg_write;
  assign ID_EX_MemRead   = id_ex_ctrl.mem_read;
  assign EX_MEM_RegWrite = ex_mem_ctrl.reg_write;
  assign EX_MEM_MemRead  = ex_mem_ctrl.mem_read;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .rs              (IF_ID_rs),
    .rt              (IF_ID_rt),
    .branch          (ID_Branch),
    .id_ex_reg_write (id_ex_ctrl.reg_write),
    .id_ex_mem_read  (id_ex_ctrl.mem_read),
    .id_ex_wr        (ID_EX_Write_register),
    .ex_mem_mem_read (ex_mem_ctrl.mem_read),
    .ex_mem_wr       (EX_MEM_Write_register),
    .stall           (stall_ID)
  );

  // NOTE: non-blocking assignments let every stage sample the previous stage's
  // old value on the same edge, which is what makes this a shift pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_ctrl            <= CTRL_BUBBLE;
      ID_EX_Write_register  <= '0;
      ex_mem_ctrl           <= CTRL_BUBBLE;
      EX_MEM_Write_register <= '0;
      EX_MEM_data           <= '0;
      MEM_WB_RegWrite       <= 1'b0;
      MEM_WB_Write_register <= '0;
      MEM_WB_data           <= '0;
      stall_count           <= '0;
    end else begin
      // A held or killed instruction leaves a bubble; a coincident stall and flush is one bubble.
      if (stall_ID || flush_ID_EX) begin
        id_ex_ctrl           <= CTRL_BUBBLE;
        ID_EX_Write_register <= REG_AW'(REG_ZERO);
      end else begin
        id_ex_ctrl           <= '{reg_write: ID_RegWrite, mem_read: ID_MemRead};
        ID_EX_Write_register <= ID_Write_register;
      end

      ex_mem_ctrl           <= id_ex_ctrl;
      EX_MEM_Write_register <= ID_EX_Write_register;
      EX_MEM_data           <= EX_ALU_out;

      MEM_WB_RegWrite       <= ex_mem_ctrl.reg_write;
      MEM_WB_Write_register <= EX_MEM_Write_register;
      MEM_WB_data           <= ex_mem_ctrl.mem_read ? MEM_Read_data : EX_MEM_data;

      if (stall_ID && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dest_track_pipe.sv
// Self-checking bench for dest_track_pipe: directed hazard table, hand-written
// corner sequences, and a randomized run against a history-based reference model.
module tb_dest_track_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] IF_ID_rs = '0, IF_ID_rt = '0, ID_Write_register = '0;
  logic          ID_Branch = 1'b0, ID_RegWrite = 1'b0, ID_MemRead = 1'b0, flush_ID_EX = 1'b0;
  logic [DW-1:0] EX_ALU_out = '0, MEM_Read_data = '0;
  logic          ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_RegWrite, EX_MEM_MemRead, MEM_WB_RegWrite;
  logic [AW-1:0] ID_EX_Write_register, EX_MEM_Write_register, MEM_WB_Write_register;
  logic [DW-1:0] EX_MEM_data, MEM_WB_data;
  logic          stall_ID;
  logic [CW-1:0] stall_count;

  dest_track_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .IF_ID_rs              (IF_ID_rs),
    .IF_ID_rt              (IF_ID_rt),
    .ID_Branch             (ID_Branch),
    .ID_RegWrite           (ID_RegWrite),
    .ID_MemRead            (ID_MemRead),
    .ID_Write_register     (ID_Write_register),
    .EX_ALU_out            (EX_ALU_out),
    .MEM_Read_data         (MEM_Read_data),
    .flush_ID_EX           (flush_ID_EX),
    .ID_EX_RegWrite        (ID_EX_RegWrite),
    .ID_EX_MemRead         (ID_EX_MemRead),
    .ID_EX_Write_register  (ID_EX_Write_register),
    .EX_MEM_RegWrite       (EX_MEM_RegWrite),
    .EX_MEM_MemRead        (EX_MEM_MemRead),
    .EX_MEM_Write_register (EX_MEM_Write_register),
    .EX_MEM_data           (EX_MEM_data),
    .MEM_WB_RegWrite       (MEM_WB_RegWrite),
    .MEM_WB_Write_register (MEM_WB_Write_register),
    .MEM_WB_data           (MEM_WB_data),
    .stall_ID              (stall_ID),
    .stall_count           (stall_count)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_id(input logic rw, input logic mr, input logic br,
                          input logic [AW-1:0] wr, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt);
    ID_RegWrite       = rw;
    ID_MemRead        = mr;
    ID_Branch         = br;
    ID_Write_register = wr;
    IF_ID_rs          = rs;
    IF_ID_rt          = rt;
  endtask

  task automatic idle();
    drive_id(1'b0, 1'b0, 1'b0, '0, '0, '0);
    flush_ID_EX = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts cycles stall_ID stays high with the current ID instruction held.
  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!stall_ID) break;
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- reference model: history of accepted ID/EX entries ----------------
  typedef struct packed { logic rw; logic mr; logic [AW-1:0] wr; } ent_t;
  ent_t          ent_q[$];
  logic [DW-1:0] alu_q[$];
  logic [DW-1:0] mrd_q[$];

  function automatic ent_t ent_at(input int i);
    return (i < 0) ? ent_t'(0) : ent_q[i];
  endfunction
  function automatic logic [DW-1:0] alu_at(input int i);
    return (i < 0) ? '0 : alu_q[i];
  endfunction
  function automatic logic [DW-1:0] mrd_at(input int i);
    return (i < 0) ? '0 : mrd_q[i];
  endfunction

  function automatic logic dep(input logic [AW-1:0] d, input logic [AW-1:0] a,
                               input logic [AW-1:0] b);
    return (d != 0) && (d == a || d == b);
  endfunction

  typedef struct {
    logic          p_mr;
    logic [AW-1:0] p_wr;
    logic          br;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    int            exp_stalls;
    string         name;
  } row_t;

  row_t rows[9];

  initial begin
    int n;
    int exp_cnt;
    ent_t idex, exmem, memwb, e;
    logic exp_stall;

    rows[0] = '{1'b1, 5'd9,  1'b0, 5'd9,  5'd3,  1, "lw9_add_rs9"};
    rows[1] = '{1'b1, 5'd9,  1'b0, 5'd4,  5'd9,  1, "lw9_add_rt9"};
    rows[2] = '{1'b1, 5'd9,  1'b1, 5'd9,  5'd2,  2, "lw9_beq_rs9"};
    rows[3] = '{1'b0, 5'd9,  1'b1, 5'd1,  5'd9,  1, "add9_beq_rt9"};
    rows[4] = '{1'b0, 5'd9,  1'b0, 5'd9,  5'd9,  0, "add9_add_rs9"};
    rows[5] = '{1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  0, "lw0_add_rs0"};
    rows[6] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  0, "lw0_beq_rs0"};
    rows[7] = '{1'b1, 5'd9,  1'b0, 5'd8,  5'd7,  0, "lw9_add_rs8"};
    rows[8] = '{1'b0, 5'd9,  1'b1, 5'd10, 5'd11, 0, "add9_beq_rs10"};

    // 1. reset state
    do_reset();
    #1;
    check("rst_idex", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_register}, '0);
    check("rst_exmem", {EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_register, EX_MEM_data}, '0);
    check("rst_memwb", {MEM_WB_RegWrite, MEM_WB_Write_register, MEM_WB_data}, '0);
    check("rst_stall", stall_ID, 0);
    check("rst_count", stall_count, 0);

    // 2. ALU op latency
    @(negedge clk); drive_id(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0);
    @(negedge clk); idle(); EX_ALU_out = 32'h1234;
    @(negedge clk); #1;
    check("alu_exmem_wr", EX_MEM_Write_register, 8);
    check("alu_exmem_rw", EX_MEM_RegWrite, 1);
    check("alu_exmem_data", EX_MEM_data, 32'h1234);
    EX_ALU_out = '0;
    @(negedge clk); #1;
    check("alu_memwb_data", MEM_WB_data, 32'h1234);
    check("alu_memwb_wr", {MEM_WB_RegWrite, MEM_WB_Write_register}, {1'b1, 5'd8});

    // 3. load write-back selects memory data
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
    @(negedge clk); idle(); EX_ALU_out = 32'h5555;
    @(negedge clk); EX_ALU_out = '0; MEM_Read_data = 32'hCAFE_F00D; #1;
    check("lw_exmem", {EX_MEM_MemRead, EX_MEM_Write_register, EX_MEM_data}, {1'b1, 5'd9, 32'h5555});
    @(negedge clk); MEM_Read_data = '0; #1;
    check("lw_memwb_data", MEM_WB_data, 32'hCAFE_F00D);

    // hazard table
    foreach (rows[i]) begin
      do_reset();
      drive_id(1'b1, rows[i].p_mr, 1'b0, rows[i].p_wr, 5'd0, 5'd0);
      @(negedge clk);
      drive_id(!rows[i].br, 1'b0, rows[i].br, 5'd12, rows[i].rs, rows[i].rt);
      count_stalls(n);
      check({rows[i].name, "_stalls"}, n, rows[i].exp_stalls);
      check({rows[i].name, "_count"}, stall_count, rows[i].exp_stalls);
      idle();
    end

    // flush together with stall: one bubble, EX/MEM advances
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
    @(negedge clk);
    drive_id(1'b1, 1'b0, 1'b0, 5'd10, 5'd9, 5'd0); flush_ID_EX = 1'b1; #1;
    check("flush_stall_hi", stall_ID, 1);
    @(negedge clk); flush_ID_EX = 1'b0; #1;
    check("flush_bubble", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_register}, '0);
    check("flush_exmem_lw", {EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_register}, {2'b11, 5'd9});
    check("flush_stall_lo", stall_ID, 0);
    @(negedge clk); #1;
    check("flush_add_enters", {ID_EX_RegWrite, ID_EX_Write_register}, {1'b1, 5'd10});
    check("flush_count", stall_count, 1);
    idle();

    // 6a. counter saturation over repeated lw/beq pairs
    do_reset();
    for (int p = 0; p < 10; p++) begin
      drive_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
      @(negedge clk);
      drive_id(1'b0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0);
      count_stalls(n);
      if (p == 6) check("sat_count_14", stall_count, 14);
    end
    check("sat_count_15", stall_count, 15);
    idle();

    // 6b. asynchronous reset mid-stall
    do_reset();
    drive_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 5'd0);
    @(negedge clk);
    drive_id(1'b0, 1'b0, 1'b1, 5'd0, 5'd9, 5'd0);
    @(negedge clk); #1;
    check("arst_pre_stall", {stall_ID, stall_count}, {1'b1, 4'd1});
    #1 reset = 1'b1;
    #1;
    check("arst_stall", stall_ID, 0);
    check("arst_count", stall_count, 0);
    check("arst_regs", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_register,
                        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_register,
                        MEM_WB_RegWrite, MEM_WB_Write_register}, '0);
    @(negedge clk); idle(); reset = 1'b0;

    // randomized run against the history model
    do_reset();
    ent_q.delete(); alu_q.delete(); mrd_q.delete();
    exp_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive_id(1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
               AW'($urandom_range(3)), AW'($urandom_range(3)), AW'($urandom_range(3)));
      flush_ID_EX   = ($urandom_range(7) == 0);
      EX_ALU_out    = $urandom;
      MEM_Read_data = $urandom;
      #1;
      n     = ent_q.size();
      idex  = ent_at(n - 1);
      exmem = ent_at(n - 2);
      memwb = ent_at(n - 3);
      exp_stall = (idex.mr && dep(idex.wr, IF_ID_rs, IF_ID_rt)) ||
                  (ID_Branch && idex.rw && dep(idex.wr, IF_ID_rs, IF_ID_rt)) ||
                  (ID_Branch && exmem.mr && dep(exmem.wr, IF_ID_rs, IF_ID_rt));
      check("rnd_stall", stall_ID, exp_stall);
      check("rnd_idex", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Write_register}, idex);
      check("rnd_exmem", {EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_Write_register, EX_MEM_data},
            {exmem, alu_at(n - 1)});
      check("rnd_memwb", {MEM_WB_RegWrite, MEM_WB_Write_register, MEM_WB_data},
            {memwb.rw, memwb.wr, memwb.mr ? mrd_at(n - 1) : alu_at(n - 2)});
      check("rnd_count", stall_count, exp_cnt);
      @(posedge clk);
      e = (exp_stall || flush_ID_EX) ? ent_t'(0) : ent_t'({ID_RegWrite, ID_MemRead, ID_Write_register});
      ent_q.push_back(e);
      alu_q.push_back(EX_ALU_out);
      mrd_q.push_back(MEM_Read_data);
      if (exp_stall && exp_cnt < 15) exp_cnt++;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
